// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, holds each fetched
// word for the controller, applies PC-relative redirects, and stops on an all-zero word.
//
// state  | meaning
// S_REQ  | read strobe issued at pc
// S_WAIT | memory word arriving; captured at the end of this cycle
// S_HOLD | instruction presented to the controller until accepted
// S_HALT | zero word fetched; idle until reset
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [9:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [31:0]       instr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instruction <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instruction;
        case (state)
            S_REQ: state_nxt = S_WAIT;
            S_WAIT: begin
                instr_nxt = imem_rdata;
                state_nxt = (imem_rdata == 32'd0) ? S_HALT : S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_nxt    = branch ? (pc + branch_offset) : (pc + PC_STEP);
                    state_nxt = S_REQ;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_REQ;
        endcase
    end

    // The reset state is REQ, so the strobe is gated until reset is released.
    assign imem_rd_en  = (state == S_REQ) && rst_n;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_HOLD);
    assign halted      = (state == S_HALT);
    assign opcode      = instruction[31:22];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized fetch streams,
// checked against a transaction-level model of the expected fetch address sequence.
module tb_instruction_fetch_unit;

    localparam int                ADDR_W   = 8;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic              clk;
    logic              rst_n;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instruction;
    logic [9:0]        opcode;
    logic [ADDR_W-1:0] pc;
    logic              branch;
    logic [ADDR_W-1:0] branch_offset;
    logic              halted;

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .opcode        (opcode),
        .pc            (pc),
        .branch        (branch),
        .branch_offset (branch_offset),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data appears the cycle after the strobe.
    logic [31:0] mem [256];
    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int exp_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_pc", 32'(pc), 32'(RESET_PC));
            chk("rst_instr", instruction, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_rd_en", 32'(imem_rd_en), 32'd1);
        chk("rel_addr", 32'(imem_addr), 32'(RESET_PC));
        exp_pc = int'(RESET_PC);
    endtask

    // Called just after the negedge that opens a REQ cycle; returns in the next REQ cycle
    // (or in the first HALT cycle when the fetched word is zero).
    task automatic fetch_one(input int stall, input logic br, input logic [7:0] off);
        logic [31:0] word;
        word = mem[exp_pc];
        chk("req_rd_en", 32'(imem_rd_en), 32'd1);
        chk("req_addr", 32'(imem_addr), 32'(exp_pc));
        chk("req_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("wait_rd_en", 32'(imem_rd_en), 32'd0);
        chk("wait_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        if (word == 32'd0) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc", 32'(pc), 32'(exp_pc));
            return;
        end
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_instr", instruction, word);
        chk("hold_opcode", 32'(opcode), word >> 22);
        chk("hold_pc", 32'(pc), 32'(exp_pc));
        for (int s = 0; s < stall; s++) begin
            instr_ready   = 1'b0;
            branch        = 1'($urandom);
            branch_offset = 8'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instruction, word);
            chk("stall_pc", 32'(pc), 32'(exp_pc));
            chk("stall_rd_en", 32'(imem_rd_en), 32'd0);
        end
        instr_ready   = 1'b1;
        branch        = br;
        branch_offset = off;
        @(negedge clk);
        instr_ready   = 1'b0;
        branch        = 1'($urandom);
        branch_offset = 8'($urandom);
        exp_pc = br ? (exp_pc + int'(off)) % 256 : (exp_pc + 1) % 256;
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        branch = 1'b0;
        branch_offset = '0;
        imem_rdata = '0;
        exp_pc = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);

        // Straight-line run ending in halt
        mem[0] = 32'h8A00_0000;
        mem[1] = 32'hCB00_0000;
        mem[2] = 32'h0000_0000;
        do_reset();
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            instr_ready = 1'b1;
            @(negedge clk);
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_no_rd", 32'(imem_rd_en), 32'd0);
            chk("halt_pc_hold", 32'(pc), 32'd2);
        end
        instr_ready = 1'b0;

        // Backpressure, branch, wrap
        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
        do_reset();
        fetch_one(5, 1'b0, 8'h00);
        chk("bp_next", 32'(exp_pc), 32'd1);
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(3, 1'b1, 8'hFE);
        chk("br_target", 32'(imem_addr), 32'd2);
        fetch_one(0, 1'b1, 8'd253);
        chk("to_255", 32'(imem_addr), 32'd255);
        fetch_one(0, 1'b0, 8'h00);
        chk("wrap_inc", 32'(imem_addr), 32'd0);
        fetch_one(0, 1'b1, 8'h01);
        fetch_one(0, 1'b1, 8'hFD);
        chk("wrap_neg", 32'(imem_addr), 32'd254);

        // Reset during WAIT with a nonzero word in flight
        fetch_one(0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rw_valid", 32'(instr_valid), 32'd0);
            chk("rw_instr", instruction, 32'd0);
            chk("rw_rd_en", 32'(imem_rd_en), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("rw_first_addr", 32'(imem_addr), 32'(RESET_PC));
        exp_pc = int'(RESET_PC);

        // Three back-to-back instructions take nine cycles
        c0 = cyc;
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(0, 1'b0, 8'h00);
        fetch_one(0, 1'b0, 8'h00);
        chk("throughput", 32'(cyc - c0), 32'd9);

        // Reset while holding an instruction
        @(negedge clk);
        @(negedge clk);
        chk("rh_valid_pre", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rh_valid", 32'(instr_valid), 32'd0);
        chk("rh_pc", 32'(pc), 32'(RESET_PC));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rh_first_addr", 32'(imem_addr), 32'(RESET_PC));
        exp_pc = int'(RESET_PC);

        // Randomized stream
        for (int n = 0; n < 150; n++)
            fetch_one($urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
        mem[exp_pc] = 32'd0;
        fetch_one(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("rand_halt", 32'(halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the word address fetched first after reset.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port imem_rd_en  output  1  read strobe to instruction memory.
REQ-007 Port imem_addr  output  ADDR_W  word address presented with imem_rd_en.
REQ-008 Port imem_rdata  input  32  instruction word, valid in the cycle after a cycle with imem_rd_en=1.
REQ-009 Port instr_valid  output  1  instruction/opcode/pc hold a fetched word for the controller.
REQ-010 Port instr_ready  input  1  controller accepts the held instruction this cycle.
REQ-011 Port instruction  output  32  held instruction word.
REQ-012 Port opcode  output  10  equals instruction[31:22].
REQ-013 Port pc  output  ADDR_W  word address of the held instruction / address being fetched.
REQ-014 Port branch  input  1  controller requests a PC-relative redirect.
REQ-015 Port branch_offset  input  ADDR_W  two's-complement word offset applied when branch is taken.
REQ-016 Port halted  output  1  an all-zero instruction was fetched; fetching stopped.

Function
REQ-017 The FSM SHALL have states REQ, WAIT, HOLD, HALT.
REQ-018 REQ: imem_rd_en=1, imem_addr=pc; next state WAIT unconditionally.
REQ-019 WAIT: imem_rd_en=0; at the rising edge ending WAIT, imem_rdata SHALL be registered into instruction; next state HOLD if the word is nonzero, HALT if it equals 0.
REQ-020 HOLD: instr_valid=1; instruction, opcode, pc SHALL stay stable while instr_ready=0.
REQ-021 HOLD with instr_ready=1: pc <= pc + branch_offset if branch=1, else pc <= pc + 1; next state REQ.
REQ-022 branch and branch_offset SHALL be sampled only on the accepting HOLD cycle; at all other times they are ignored.
REQ-023 PC arithmetic SHALL be modulo 2^ADDR_W (pc=2^ADDR_W-1 increments to 0; negative offsets wrap likewise).
REQ-024 HALT: instr_valid=0, imem_rd_en=0, halted=1; state SHALL remain HALT until rst_n is asserted.
REQ-025 instr_valid SHALL be 1 only in HOLD; imem_rd_en SHALL be 1 only in REQ.
REQ-026 Latency: instr_valid SHALL rise after the 2nd rising edge following a REQ cycle; sustained throughput SHALL be one instruction per 3 cycles with instr_ready held at 1.
REQ-027 imem_addr SHALL equal pc in all states (value only meaningful when imem_rd_en=1).

Reset
REQ-028 rst_n=0 SHALL immediately force state REQ, pc=RESET_PC, instruction=0, instr_valid=0, halted=0, imem_rd_en driven per REQ state only after rst_n=1 (held 0 while rst_n=0).
REQ-029 Reset asserted in WAIT or HOLD SHALL discard any in-flight or held word; the first fetch after release SHALL be from RESET_PC.
REQ-030 The first REQ cycle SHALL be the first clock cycle with rst_n=1.

Verification
REQ-031 Straight-line: memory[0..2]=0x8A000000,0xCB000000,0x00000000, instr_ready=1 -> instr_valid with opcode 0x228 at pc 0, then 0x32C at pc 1, then halted=1 with pc=2, no further imem_rd_en.
REQ-032 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instruction and pc unchanged, imem_rd_en stays 0; accept on 6th cycle -> next REQ at pc+1.
REQ-033 Branch: at pc=4 accept with branch=1, branch_offset=0xFE (-2) -> next imem_addr=2; branch=1 on a non-accepting cycle -> no effect.
REQ-034 Wrap: ADDR_W=8, pc=255, accept with branch=0 -> next imem_addr=0; pc=1 with offset 0xFD -> 254.
REQ-035 Reset mid-operation: assert rst_n=0 during WAIT with nonzero imem_rdata -> instr_valid never rises for that word; after release, first imem_addr=RESET_PC.
REQ-036 Timing: from first REQ cycle to instr_valid=1 SHALL be exactly 2 edges; 3 instructions with instr_ready=1 SHALL take 9 cycles.
